// File: rtl/uart_pkg.sv
// Shared constants for the UART peripheral: receiver FSM states and the
// layout of the status/data word returned on a bus read.
package uart_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  localparam int RDATA_VALID = 31;
  localparam int RDATA_OVR   = 9;
  localparam int RDATA_FERR  = 8;

  function automatic logic [31:0] make_rdata(input logic valid, input logic ovr,
                                             input logic ferr, input logic [7:0] data);
    logic [31:0] w;
    w = '0;
    w[RDATA_VALID] = valid;
    w[RDATA_OVR]   = ovr;
    w[RDATA_FERR]  = ferr;
    w[7:0]         = data;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received characters. Pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate count.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled mid-bit recovery into a FIFO, drained by
// a request/ready bus read that also reports sticky overrun/framing status.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_available,
  input  logic        UART_RX
);
  localparam int DIV = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [1:0]    sync;
  logic          rx;
  logic [DW-1:0] divcnt;
  logic          tick;
  logic [2:0]    state;
  logic [3:0]    scnt;
  logic [2:0]    bcnt;
  logic [7:0]    shreg;
  logic          push, ferr_evt, ovr_evt;
  logic          rd_start, pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic          ovr, ferr;

  always_ff @(posedge i_clock) begin
    if (i_reset) sync <= 2'b11;
    else         sync <= {sync[0], UART_RX};
  end
  assign rx = sync[1];

  assign tick = (divcnt == DW'(DIV - 1));
  always_ff @(posedge i_clock) begin
    if (i_reset)   divcnt <= '0;
    else if (tick) divcnt <= '0;
    else           divcnt <= divcnt + 1'b1;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      scnt  <= '0;
      bcnt  <= '0;
      shreg <= '0;
    end else if (tick) begin
      case (state)
        IDLE: if (!rx) begin
          state <= START;
          scnt  <= '0;
        end
        START: begin
          if (scnt == 4'd7) begin
            if (!rx) begin
              state <= DATA;
              scnt  <= '0;
              bcnt  <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            scnt <= scnt + 4'd1;
          end
        end
        DATA: begin
          // scnt wraps 15->0, so each data bit is sampled one bit period after the last.
          scnt <= scnt + 4'd1;
          if (scnt == 4'd15) begin
            shreg <= {rx, shreg[7:1]};
            if (bcnt == 3'd7) state <= STOP;
            else              bcnt  <= bcnt + 3'd1;
          end
        end
        STOP: begin
          scnt <= scnt + 4'd1;
          if (scnt == 4'd15) state <= rx ? IDLE : BREAK;
        end
        BREAK: if (rx) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign push     = tick && (state == STOP) && (scnt == 4'd15) && rx;
  assign ferr_evt = tick && (state == STOP) && (scnt == 4'd15) && !rx;
  assign rd_start = i_request && !o_ready;
  assign pop      = rd_start && !fifo_empty;
  assign ovr_evt  = push && fifo_full && !pop;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .push    (push),
    .wdata   (shreg),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The reading cycle clears a flag unless a new event lands in that same cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else if (rd_start) begin
      ovr  <= ovr_evt;
      ferr <= ferr_evt;
    end else begin
      ovr  <= ovr  | ovr_evt;
      ferr <= ferr | ferr_evt;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_ready <= 1'b0;
      o_rdata <= '0;
    end else if (rd_start) begin
      o_ready <= 1'b1;
      o_rdata <= make_rdata(!fifo_empty, ovr, ferr, fifo_empty ? 8'h00 : fifo_rdata);
    end else if (o_ready && !i_request) begin
      o_ready <= 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) o_available <= 1'b0;
    else         o_available <= !fifo_empty || push;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven on the line, a byte-level
// model predicts each read word, and a monitor checks words as o_ready rises.
module tb_uart_rx;
  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_request;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        o_available;
  logic        UART_RX;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  mq[$];
  bit          m_ovr, m_ferr;

  uart_rx #(.CLOCK_RATE(16000000), .BAUD_RATE(1000000), .FIFO_DEPTH(16)) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_request   (i_request),
    .o_rdata     (o_rdata),
    .o_ready     (o_ready),
    .o_available (o_available),
    .UART_RX     (UART_RX)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: 16-entry byte queue with sticky flags.
  function automatic void model_frame(input logic [7:0] b, input bit ok);
    if (!ok)                  m_ferr = 1;
    else if (mq.size() == 16) m_ovr  = 1;
    else                      mq.push_back(b);
  endfunction

  function automatic logic [31:0] model_read();
    logic [31:0] w;
    w = 32'h0;
    if (mq.size() > 0) begin
      w[31]  = 1'b1;
      w[7:0] = mq.pop_front();
    end
    w[9] = m_ovr;
    w[8] = m_ferr;
    m_ovr  = 0;
    m_ferr = 0;
    return w;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ovr  = 0;
    m_ferr = 0;
  endfunction

  // Monitor: one comparison per o_ready rising edge, plus data stability while high.
  initial begin
    logic        ready_q;
    logic [31:0] held, e;
    ready_q = 1'b0;
    held    = '0;
    forever begin
      @(posedge i_clock);
      #1;
      if (o_ready && !ready_q) begin
        held = o_rdata;
        if (exp_q.size() == 0) begin
          check("unexpected_read", o_rdata, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          check("read_word", o_rdata, e);
        end
      end else if (o_ready && ready_q) begin
        check("rdata_stable", o_rdata, held);
      end
      ready_q = o_ready;
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit ok, input int extra_low);
    @(negedge i_clock) UART_RX = 1'b0;
    repeat (16) @(negedge i_clock);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (16) @(negedge i_clock);
    end
    UART_RX = ok;
    repeat (16) @(negedge i_clock);
    if (!ok) repeat (extra_low) @(negedge i_clock);
    UART_RX = 1'b1;
    repeat (6) @(negedge i_clock);
    model_frame(b, ok);
  endtask

  task automatic do_read(input int hold);
    int n;
    exp_q.push_back(model_read());
    @(negedge i_clock) i_request = 1'b1;
    n = 0;
    do begin
      @(negedge i_clock);
      n++;
    end while (!o_ready && n < 20);
    if (!o_ready) check("ready_timeout", {31'b0, o_ready}, 32'd1);
    repeat (hold) @(negedge i_clock);
    i_request = 1'b0;
    n = 0;
    do begin
      @(negedge i_clock);
      n++;
    end while (o_ready && n < 5);
    check("ready_clear", {31'b0, o_ready}, 32'd0);
  endtask

  task automatic check_avail(input string name);
    @(negedge i_clock);
    check(name, {31'b0, o_available}, {31'b0, mq.size() > 0});
  endtask

  initial begin
    int n, cnt;
    logic [7:0] b;
    bit ok;
    i_reset   = 1'b1;
    i_request = 1'b0;
    UART_RX   = 1'b1;
    model_reset();
    repeat (4) @(negedge i_clock);
    check("reset_ready", {31'b0, o_ready}, 32'd0);
    check("reset_rdata", o_rdata, 32'd0);
    check("reset_avail", {31'b0, o_available}, 32'd0);
    i_reset = 1'b0;
    repeat (4) @(negedge i_clock);

    // Single byte then an empty read
    send_frame(8'h55, 1, 0);
    check_avail("avail_after_55");
    do_read(0);
    do_read(0);

    // Short glitch on the line must not produce a byte
    @(negedge i_clock) UART_RX = 1'b0;
    repeat (4) @(negedge i_clock);
    UART_RX = 1'b1;
    repeat (30) @(negedge i_clock);
    check_avail("avail_after_glitch");

    // Framing error with a held-low break, then a clean byte
    send_frame(8'hA5, 0, 40);
    send_frame(8'h3C, 1, 0);
    do_read(0);
    do_read(0);

    // Overrun: 17 bytes with no reads
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1, 0);
    check_avail("avail_full");
    for (int i = 0; i < 17; i++) do_read(0);
    check_avail("avail_drained");

    // Long request hold: one pop, ready high for the whole hold
    send_frame(8'h11, 1, 0);
    send_frame(8'h22, 1, 0);
    exp_q.push_back(model_read());
    @(negedge i_clock) i_request = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clock);
      if (o_ready) cnt++;
    end
    i_request = 1'b0;
    @(negedge i_clock);
    if (o_ready) cnt++;
    @(negedge i_clock);
    check("hold_ready_cycles", cnt, 32'd10);
    check("hold_ready_low", {31'b0, o_ready}, 32'd0);
    check_avail("hold_second_left");
    do_read(0);

    // Reset in the middle of a frame
    @(negedge i_clock) UART_RX = 1'b0;
    repeat (16) @(negedge i_clock);
    b = 8'h81;
    for (int i = 0; i < 4; i++) begin
      UART_RX = b[i];
      repeat (16) @(negedge i_clock);
    end
    i_reset = 1'b1;
    UART_RX = 1'b1;
    model_reset();
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
    check("midreset_ready", {31'b0, o_ready}, 32'd0);
    check("midreset_rdata", o_rdata, 32'd0);
    check("midreset_avail", {31'b0, o_available}, 32'd0);
    repeat (4) @(negedge i_clock);
    send_frame(8'h42, 1, 0);
    do_read(0);

    // Randomized batches, occasionally with bad stop bits or overflow
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 18);
      for (int i = 0; i < n; i++) begin
        b  = 8'($urandom);
        ok = ($urandom_range(0, 7) != 0);
        send_frame(b, ok, $urandom_range(0, 20));
      end
      check_avail("rand_avail");
      for (int i = 0; i <= n; i++) do_read($urandom_range(0, 3));
    end

    repeat (10) @(negedge i_clock);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
